switch_debounce_multi: RTL and testbench

Parametrised multi-channel switch debouncer. It is the successor to the single-switch 8-state debouncer. Each of `CHANNELS` raw switch inputs is optionally synchronised, then filtered by a per-channel counter that needs `TICKS` consecutive `swtick` strobes of a stable new level before the debounced output changes. The block sits between board switches, buttons and keyboard lines and the system logic. It also supplies per-channel rise/fall pulses and a busy flag, so consumers need no edge detection of their own.

---
 rtl/switch_debounce_pkg.sv | 14 +
 rtl/switch_debounce_channel.sv | 66 ++++++
 rtl/switch_debounce_multi.sv | 70 +++++++
 tb/tb_switch_debounce_multi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package switch_debounce_pkg;

    localparam int   DEF_TICKS       = 3;
    localparam logic DEF_RESET_LEVEL = 1'b1;

    // Width of a counter holding 0..ticks, never narrower than one bit.
    function automatic int cnt_width(input int ticks);
        int w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One debouncer channel: stable-level counter, debounced level and edge pulses.
module switch_debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int   TICKS       = DEF_TICKS,
    parameter logic RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic swclock,
    input  logic reset,
    input  logic swtick,
    input  logic s,
    output logic dbsw,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW   = cnt_width(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbsw_q, dbsw_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Count ticks of disagreement; any agreeing sample clears the count at once.
    always_comb begin
        dbsw_d = dbsw_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == dbsw_q) begin
            cnt_d = '0;
        end else if (swtick) begin
            if (cnt_q == LAST) begin
                dbsw_d = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state register; reset drops any pending change without a pulse.
    always_ff @(posedge swclock) begin
        if (reset) begin
            dbsw_q <= RESET_LEVEL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            dbsw_q <= dbsw_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dbsw = dbsw_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = |cnt_q;

endmodule

// File: rtl/switch_debounce_multi.sv
// Multi-channel switch debouncer top.
// Define SWITCH_DEBOUNCE_SYNC_EN to put a 2-flop synchroniser on every input
// (adds 2 swclock cycles of latency); otherwise sw must already be synchronous.
module switch_debounce_multi
    import switch_debounce_pkg::*;
#(
    parameter int   CHANNELS    = 8,
    parameter int   TICKS       = DEF_TICKS,
    parameter logic RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic                swclock,
    input  logic                reset,
    input  logic                swtick,
    input  logic [CHANNELS-1:0] sw,
    output logic [CHANNELS-1:0] dbsw,
    output logic [CHANNELS-1:0] dbsw_neg,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy,
    output logic                any_change
);

    logic [CHANNELS-1:0] s;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;

    // Synchroniser next-state: shift raw levels through two stages.
    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

    // Synchroniser flops start at the reset level so no false edge is seen.
    always_ff @(posedge swclock) begin
        if (reset) begin
            sync1_q <= {CHANNELS{RESET_LEVEL}};
            sync2_q <= {CHANNELS{RESET_LEVEL}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = sw;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        switch_debounce_channel #(
            .TICKS       (TICKS),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .swclock (swclock),
            .reset   (reset),
            .swtick  (swtick),
            .s       (s[i]),
            .dbsw    (dbsw[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .busy    (busy[i])
        );
    end

    assign dbsw_neg   = ~dbsw;
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_switch_debounce_multi.sv
// Bench for switch_debounce_multi: table vectors, corner sequences and random
// stimulus against a tick-counting reference model. Two instances: TICKS=3 and TICKS=1.
module tb_switch_debounce_multi;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       swclock = 1'b0;
    logic       reset   = 1'b1;
    logic       tick0   = 1'b0;
    logic       tick1   = 1'b0;
    logic [3:0] sw0     = 4'hF;
    logic [3:0] sw1     = 4'hF;
    logic [3:0] dbsw0, dbswn0, rise0, fall0, busy0;
    logic [3:0] dbsw1, dbswn1, rise1, fall1, busy1;
    logic       any0, any1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 swclock = ~swclock;

    switch_debounce_multi #(.CHANNELS(4), .TICKS(3), .RESET_LEVEL(1'b1)) dut (
        .swclock(swclock), .reset(reset), .swtick(tick0), .sw(sw0),
        .dbsw(dbsw0), .dbsw_neg(dbswn0), .rise(rise0), .fall(fall0),
        .busy(busy0), .any_change(any0)
    );

    switch_debounce_multi #(.CHANNELS(4), .TICKS(1), .RESET_LEVEL(1'b1)) dut1 (
        .swclock(swclock), .reset(reset), .swtick(tick1), .sw(sw1),
        .dbsw(dbsw1), .dbsw_neg(dbswn1), .rise(rise1), .fall(fall1),
        .busy(busy1), .any_change(any1)
    );

    // Reference model: per channel, number of ticks seen while the sampled
    // input has disagreed with the debounced level.
    int         m_ticks [2] = '{3, 1};
    logic [3:0] m_lvl   [2];
    int         m_run   [2][4];
    logic [3:0] m_rise  [2];
    logic [3:0] m_fall  [2];
    logic [3:0] m_hist  [2][2];

    task automatic model_edge(input int k, input logic [3:0] raw, input logic t, input logic r);
        logic [3:0] s;
`ifdef SWITCH_DEBOUNCE_SYNC_EN
        s = m_hist[k][1];
        if (r) begin
            m_hist[k][0] = 4'hF;
            m_hist[k][1] = 4'hF;
        end else begin
            m_hist[k][1] = m_hist[k][0];
            m_hist[k][0] = raw;
        end
`else
        s = raw;
`endif
        m_rise[k] = 4'h0;
        m_fall[k] = 4'h0;
        if (r) begin
            m_lvl[k] = 4'hF;
            for (int c = 0; c < 4; c++) m_run[k][c] = 0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            if (s[c] == m_lvl[k][c]) begin
                m_run[k][c] = 0;
            end else if (t) begin
                m_run[k][c] = m_run[k][c] + 1;
                if (m_run[k][c] >= m_ticks[k]) begin
                    m_lvl[k][c] = s[c];
                    m_run[k][c] = 0;
                    if (s[c]) m_rise[k][c] = 1'b1;
                    else      m_fall[k][c] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [3:0] m_busy(input int k);
        logic [3:0] b;
        for (int c = 0; c < 4; c++) b[c] = (m_run[k][c] != 0);
        return b;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("d0_dbsw", dbsw0, m_lvl[0]);
        chk("d0_dbsw_neg", dbswn0, ~m_lvl[0]);
        chk("d0_rise", rise0, m_rise[0]);
        chk("d0_fall", fall0, m_fall[0]);
        chk("d0_busy", busy0, m_busy(0));
        chk("d0_any", {3'b0, any0}, {3'b0, |(m_rise[0] | m_fall[0])});
        chk("d1_dbsw", dbsw1, m_lvl[1]);
        chk("d1_dbsw_neg", dbswn1, ~m_lvl[1]);
        chk("d1_rise", rise1, m_rise[1]);
        chk("d1_fall", fall1, m_fall[1]);
        chk("d1_busy", busy1, m_busy(1));
        chk("d1_any", {3'b0, any1}, {3'b0, |(m_rise[1] | m_fall[1])});
    endtask

    // One clock: drive inputs at the negedge, advance the model, check at next negedge.
    task automatic step(input logic [3:0] a, input logic ta, input logic [3:0] b,
                        input logic tb_, input logic r);
        sw0 = a; tick0 = ta; sw1 = b; tick1 = tb_; reset = r;
        model_edge(0, a, ta, r);
        model_edge(1, b, tb_, r);
        @(posedge swclock);
        @(negedge swclock);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(sw0, 1'b0, sw1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [3:0] sw;
        logic       tick;
        logic [3:0] dbsw;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } vec_t;

    vec_t vec [10];

    initial begin
        int lat;
        logic [3:0] r0, r1;

        // sw0[0] falls; two quiet cycles let any synchroniser settle first.
        vec[0] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0};
        vec[1] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0};
        vec[2] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0};
        vec[3] = '{4'b1110, 1'b1, 4'b1111, 4'h0, 4'h0, 4'b0001};
        vec[4] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'b0001};
        vec[5] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'b0001};
        vec[6] = '{4'b1110, 1'b1, 4'b1111, 4'h0, 4'h0, 4'b0001};
        vec[7] = '{4'b1110, 1'b0, 4'b1111, 4'h0, 4'h0, 4'b0001};
        vec[8] = '{4'b1110, 1'b1, 4'b1110, 4'h0, 4'b0001, 4'h0};
        vec[9] = '{4'b1110, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0};

        m_lvl[0] = 4'hF; m_lvl[1] = 4'hF;
        for (int k = 0; k < 2; k++) begin
            m_rise[k] = 4'h0; m_fall[k] = 4'h0;
            m_hist[k][0] = 4'hF; m_hist[k][1] = 4'hF;
            for (int c = 0; c < 4; c++) m_run[k][c] = 0;
        end

        // Reset state
        step(4'hF, 1'b0, 4'hF, 1'b0, 1'b1);
        step(4'hF, 1'b0, 4'hF, 1'b0, 1'b1);
        chk("reset_dbsw", dbsw0, 4'b1111);
        chk("reset_rise_fall_busy", rise0 | fall0 | busy0, 4'h0);
        chk("reset_any", {3'b0, any0}, 4'h0);
        step(4'hF, 1'b0, 4'hF, 1'b0, 1'b0);

        // Table: flip latency on channel 0, fall pulse for exactly one cycle
        for (int i = 0; i < 10; i++) begin
            step(vec[i].sw, vec[i].tick, 4'hF, 1'b0, 1'b0);
            chk($sformatf("vec%0d_dbsw", i), dbsw0, vec[i].dbsw);
            chk($sformatf("vec%0d_rise", i), rise0, vec[i].rise);
            chk($sformatf("vec%0d_fall", i), fall0, vec[i].fall);
            chk($sformatf("vec%0d_busy", i), busy0, vec[i].busy);
            chk($sformatf("vec%0d_any", i), {3'b0, any0}, {3'b0, |vec[i].fall});
        end

        // Bounce on channel 1: two ticks, one-cycle return, then three more ticks
        step(4'b1100, 1'b0, 4'hF, 1'b0, 1'b0);
        idle(2);
        step(4'b1100, 1'b1, 4'hF, 1'b0, 1'b0); idle(3);
        step(4'b1100, 1'b1, 4'hF, 1'b0, 1'b0);
        chk("bounce_busy_before", busy0, 4'b0010);
        step(4'b1110, 1'b0, 4'hF, 1'b0, 1'b0);
        step(4'b1100, 1'b0, 4'hF, 1'b0, 1'b0); idle(3);
        chk("bounce_busy_cleared", busy0, 4'b0000);
        for (int t = 0; t < 2; t++) begin
            step(4'b1100, 1'b1, 4'hF, 1'b0, 1'b0); idle(3);
            chk("bounce_no_early_fall", dbsw0, 4'b1110);
        end
        step(4'b1100, 1'b1, 4'hF, 1'b0, 1'b0);
        chk("bounce_fall", fall0, 4'b0010);
        chk("bounce_dbsw", dbsw0, 4'b1100);

        // Return coincident with a tick at cnt=2 on channel 3
        step(4'b0100, 1'b0, 4'hF, 1'b0, 1'b0); idle(2);
        step(4'b0100, 1'b1, 4'hF, 1'b0, 1'b0); idle(1);
        step(4'b0100, 1'b1, 4'hF, 1'b0, 1'b0);
        chk("coinc_busy_cnt2", busy0, 4'b1000);
        step(4'b1100, (SYNC_LAT == 0), 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < SYNC_LAT; i++)
            step(4'b1100, (i == SYNC_LAT - 1), 4'hF, 1'b0, 1'b0);
        chk("coinc_busy_clear", busy0, 4'b0000);
        chk("coinc_no_flip", dbsw0 | fall0, 4'b1100);

        // Reset while channel 2 sits at cnt=2
        step(4'b1000, 1'b0, 4'hF, 1'b0, 1'b0); idle(2);
        step(4'b1000, 1'b1, 4'hF, 1'b0, 1'b0); idle(1);
        step(4'b1000, 1'b1, 4'hF, 1'b0, 1'b0);
        chk("rst_mid_busy", busy0 & 4'b0100, 4'b0100);
        step(4'b1111, 1'b0, 4'hF, 1'b0, 1'b1);
        chk("rst_mid_dbsw", dbsw0, 4'b1111);
        chk("rst_mid_no_pulse", rise0 | fall0, 4'h0);
        idle(3);

        // Latency with swtick held high: TICKS plus synchroniser delay
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(4'b1110, 1'b1, 4'hF, 1'b0, 1'b0);
            if (dbsw0[0] == 1'b0) lat = i;
        end
        chk("latency_cycles", 4'(lat), 4'(3 + SYNC_LAT));
        step(4'b1111, 1'b0, 4'hF, 1'b0, 1'b0); idle(2);

        // TICKS=1: channels 2 and 3 flip in opposite directions on one tick
        step(4'hF, 1'b0, 4'b0111, 1'b0, 1'b0); idle(2);
        step(4'hF, 1'b0, 4'b0111, 1'b1, 1'b0);
        chk("t1_pre_fall", fall1, 4'b1000);
        step(4'hF, 1'b0, 4'b1011, 1'b0, 1'b0); idle(2);
        step(4'hF, 1'b0, 4'b1011, 1'b1, 1'b0);
        chk("t1_rise", rise1, 4'b1000);
        chk("t1_fall", fall1, 4'b0100);
        chk("t1_any", {3'b0, any1}, 4'b0001);
        chk("t1_dbsw", dbsw1, 4'b1011);
        idle(1);
        chk("t1_any_once", {3'b0, any1}, 4'b0000);

        // Random stimulus against the model
        r0 = sw0; r1 = sw1;
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = (i < 1500) ? 3 : 1;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 19) < p) r0[c] = ~r0[c];
                if ($urandom_range(0, 19) < p) r1[c] = ~r1[c];
            end
            step(r0, ($urandom_range(0, 2) == 0) || (i >= 2500), r1,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
